uart_tx_fifo_reader: RTL

- Consumer end of the 8-bit TX FIFO: pops bytes and serialises each as an 8N1 UART frame on `tx`.
- Sits between the TX FIFO read port and the UART pin.
- The APB register block drives `enable`.

---
 rtl/uart_tx_fifo_reader_pkg.sv | 27 ++
 rtl/uart_tx_fifo_reader_baud_counter.sv | 42 ++++
 rtl/uart_tx_fifo_reader.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/uart_tx_fifo_reader_pkg.sv
// uart_tx_fifo_reader_pkg
// Definitions shared by the UART transmit path, and later by the receiver:
//   - state_e          : FSM state encodings (3 bits)
//   - StartBit/StopBit : line levels of the frame delimiters
//   - DefaultClksPerBit: default clk cycles per bit period
// Configuration macro: UART_TX_PARITY_EN adds the StParity state.

package uart_tx_fifo_reader_pkg;

   localparam int unsigned DefaultClksPerBit = 868;

   localparam logic StartBit = 1'b0;
   localparam logic StopBit  = 1'b1;

   typedef enum logic [2:0] {
      StIdle   = 3'd0,
      StFetch  = 3'd1,
      StWait   = 3'd2,
      StStart  = 3'd3,
      StData   = 3'd4,
`ifdef UART_TX_PARITY_EN
      StParity = 3'd5,
`endif
      StStop   = 3'd6
   } state_e;

endpackage

// File: rtl/uart_tx_fifo_reader_baud_counter.sv
// uart_tx_fifo_reader_baud_counter
// Bit-period timer for the UART transmitter. Counts 0..CLKS_PER_BIT-1 and wraps.
// Ports:
//   clk    : system clock
//   reset  : asynchronous active-low reset
//   clear  : hold the count at zero (used outside the bit-timed states)
//   bitEnd : high on the last cycle of each bit period

module uart_tx_fifo_reader_baud_counter
   import uart_tx_fifo_reader_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = DefaultClksPerBit
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   output logic bitEnd
);

   localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);

   logic [CntW-1:0] cnt_q, cnt_d;

   assign bitEnd = (cnt_q == CntLast);

   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (clear || bitEnd) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_tx_fifo_reader.sv
// uart_tx_fifo_reader
// Pops bytes from the TX FIFO and sends each as an 8N1 UART frame on tx.
// Configuration macro: UART_TX_PARITY_EN inserts an even-parity bit before the stop bit.
// Ports:
//   clk        : system clock, all logic on the rising edge
//   reset      : asynchronous active-low reset
//   enable     : permits fetching the next byte
//   fifoEmpty  : FIFO empty flag
//   fifoData   : FIFO read data, valid the cycle after a pop
//   fifoReadEn : one-cycle pop strobe per byte
//   tx         : serial line, idle high
//   busy       : high from the fetch cycle through the last stop-bit cycle
//   txDone     : one-cycle pulse on the last stop-bit cycle

module uart_tx_fifo_reader
   import uart_tx_fifo_reader_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = DefaultClksPerBit,
   parameter int unsigned DATA_WIDTH   = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   input  logic                  fifoEmpty,
   input  logic [DATA_WIDTH-1:0] fifoData,
   output logic                  fifoReadEn,
   output logic                  tx,
   output logic                  busy,
   output logic                  txDone
);

   localparam int unsigned IdxW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [IdxW-1:0] IdxLast = IdxW'(DATA_WIDTH - 1);

   state_e                state_q, state_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic [IdxW-1:0]       idx_q, idx_d;
   logic                  bit_end;
   logic                  baud_clear;
`ifdef UART_TX_PARITY_EN
   logic                  parity_q, parity_d;
`endif

   uart_tx_fifo_reader_baud_counter #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud (
      .clk   (clk),
      .reset (reset),
      .clear (baud_clear),
      .bitEnd(bit_end)
   );

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= StIdle;
         shift_q  <= '0;
         idx_q    <= '0;
`ifdef UART_TX_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         shift_q  <= shift_d;
         idx_q    <= idx_d;
`ifdef UART_TX_PARITY_EN
         parity_q <= parity_d;
`endif
      end
   end

   // Next-state logic
   always_comb begin
      state_d  = state_q;
      shift_d  = shift_q;
      idx_d    = idx_q;
`ifdef UART_TX_PARITY_EN
      parity_d = parity_q;
`endif
      case (state_q)
         StIdle: begin
            if (enable && !fifoEmpty) begin
               state_d = StFetch;
            end
         end
         StFetch: state_d = StWait;
         StWait: begin
            // Read data became valid in FETCH and is held by the FIFO.
            shift_d  = fifoData;
            idx_d    = '0;
`ifdef UART_TX_PARITY_EN
            parity_d = ^fifoData;
`endif
            state_d  = StStart;
         end
         StStart: begin
            if (bit_end) begin
               state_d = StData;
            end
         end
         StData: begin
            if (bit_end) begin
               shift_d = shift_q >> 1;
               idx_d   = idx_q + 1'b1;
               if (idx_q == IdxLast) begin
`ifdef UART_TX_PARITY_EN
                  state_d = StParity;
`else
                  state_d = StStop;
`endif
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         StParity: begin
            if (bit_end) begin
               state_d = StStop;
            end
         end
`endif
         StStop: begin
            if (bit_end) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Outputs
   always_comb begin
      fifoReadEn = 1'b0;
      tx         = StopBit;
      busy       = 1'b1;
      txDone     = 1'b0;
      baud_clear = 1'b0;
      case (state_q)
         StIdle: begin
            busy       = 1'b0;
            baud_clear = 1'b1;
            // Gated by reset so no pop is requested while the block is held in reset.
            fifoReadEn = reset && enable && !fifoEmpty;
         end
         StFetch: baud_clear = 1'b1;
         StWait:  baud_clear = 1'b1;
         StStart: tx = StartBit;
         StData:  tx = shift_q[0];
`ifdef UART_TX_PARITY_EN
         StParity: tx = parity_q;
`endif
         StStop:  txDone = bit_end;
         default: begin
            busy       = 1'b0;
            baud_clear = 1'b1;
         end
      endcase
   end

endmodule
